adc_frame_deser: RTL and testbench

ADC_FRAME_DESER -- requirements
Module: adc_frame_deser

---
 rtl/adc_frame_deser.sv | 191 +++++++++++++++++++
 tb/tb_adc_frame_deser.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_deser.sv
`timescale 1ns/1ps
// Frame-aligning deserialiser for multi-lane DDR ADC outputs (FCO-based word lock with bit slip).
// Latency: samples and Data_VLD register one DCO cycle after the frame-wrap edge.
// Backpressure: none; the ADC stream free-runs and Data_VLD is a strobe with no ready.
// Ports: DCO/RST_N clock and async reset; Data_R/Data_F/FCO_R/FCO_F lane bits, fall bit first;
//   Realign forces re-hunt; Data_VLD/Data_CH sample strobe and bus; Locked, Slip, Err_Cnt status.

module adc_frame_deser #(
  parameter int CHANNELS  = 4,
  parameter int RES       = 14,
  parameter int LANES     = 2,
  parameter int LANE_BITS = 8,
  parameter int LOCK_CNT  = 8,
  parameter int LOSS_CNT  = 4
) (
  input  logic                         DCO,
  input  logic                         RST_N,
  input  logic [CHANNELS*LANES-1:0]    Data_R,
  input  logic [CHANNELS*LANES-1:0]    Data_F,
  input  logic                         FCO_R,
  input  logic                         FCO_F,
  input  logic                         Realign,
  output logic                         Data_VLD,
  output logic [CHANNELS*RES-1:0]      Data_CH,
  output logic                         Locked,
  output logic [$clog2(LANE_BITS)-1:0] Slip,
  output logic [15:0]                  Err_Cnt
);

  localparam int NL   = CHANNELS * LANES;
  localparam int HW   = 2 * LANE_BITS;
  localparam int HALF = LANE_BITS / 2;
  localparam int WW   = LANES * LANE_BITS;
  localparam int SW   = $clog2(LANE_BITS);
  localparam int FW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int BW   = $clog2(LOSS_CNT + 1);
  localparam logic [LANE_BITS-1:0] FCO_GOOD = {{HALF{1'b1}}, {HALF{1'b0}}};

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_CHECK     = 2'd2,
    ST_LOCKED    = 2'd3
  } state_t;

  logic [NL-1:0][HW-1:0]   hist_q, hist_d;
  logic [HW-1:0]           fco_q, fco_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic                    frm_q, frm_d;
  state_t                  state_q, state_d;
  logic [SW-1:0]           slip_q, slip_d;
  logic [GW-1:0]           gcnt_q, gcnt_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic [15:0]             err_q, err_d;
  logic                    vld_q, vld_d;
  logic [CHANNELS*RES-1:0] dat_q, dat_d;
  logic [CHANNELS*RES-1:0] samp_w;
  logic                    fco_good;

  // Slip counts bit positions back from the newest bit in the window;
  // Slip=0 takes the most recent LANE_BITS bits.
  function automatic logic [LANE_BITS-1:0] pick(input logic [HW-1:0] h, input logic [SW-1:0] s);
    return LANE_BITS'(h >> s);
  endfunction

  // History windows shift two bits per cycle, fall sample first so the
  // newest (rise) bit lands at bit 0. frm_q marks the cycle after a frame wrap.
  always_comb begin
    hist_d = hist_q;
    for (int i = 0; i < NL; i++) begin
      hist_d[i] = {hist_q[i][HW-3:0], Data_F[i], Data_R[i]};
    end
    fco_d  = {fco_q[HW-3:0], FCO_F, FCO_R};
    frm_d  = (fcnt_q == FW'(HALF - 1));
    fcnt_d = frm_d ? '0 : fcnt_q + 1'b1;
  end

  // Lane words concatenate high lane first; the top RES bits are the sample.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WW-1:0] cat;
    for (genvar l = 0; l < LANES; l++) begin : g_ln
      assign cat[l*LANE_BITS +: LANE_BITS] = pick(hist_q[c*LANES+l], slip_q);
    end
    assign samp_w[c*RES +: RES] = RES'(cat >> (WW - RES));
  end

  assign fco_good = (pick(fco_q, slip_q) == FCO_GOOD);

  always_comb begin
    state_d = state_q;
    slip_d  = slip_q;
    gcnt_d  = gcnt_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    dat_d   = dat_q;
    if (Realign) begin
      // Realign wins over a frame evaluated in the same cycle.
      state_d = ST_HUNT;
      gcnt_d  = '0;
      bcnt_d  = '0;
    end else if (frm_q) begin
      case (state_q)
        ST_HUNT: begin
          if (fco_good) begin
            if (LOCK_CNT <= 1) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_CHECK;
              gcnt_d  = GW'(1);
            end
          end else begin
            slip_d  = (slip_q == SW'(LANE_BITS - 1)) ? '0 : slip_q + 1'b1;
            state_d = ST_SLIP_WAIT;
          end
        end
        ST_SLIP_WAIT: begin
          // The frame straddling the new slip is not trusted.
          state_d = ST_HUNT;
        end
        ST_CHECK: begin
          if (fco_good) begin
            if (gcnt_q == GW'(LOCK_CNT - 1)) begin
              state_d = ST_LOCKED;
              gcnt_d  = '0;
            end else begin
              gcnt_d = gcnt_q + 1'b1;
            end
          end else begin
            state_d = ST_HUNT;
            gcnt_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (fco_good) begin
            bcnt_d = '0;
            vld_d  = 1'b1;
            dat_d  = samp_w;
          end else begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            if (bcnt_q == BW'(LOSS_CNT - 1)) begin
              state_d = ST_HUNT;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge DCO or negedge RST_N) begin
    if (!RST_N) begin
      hist_q  <= '0;
      fco_q   <= '0;
      fcnt_q  <= '0;
      frm_q   <= 1'b0;
      state_q <= ST_HUNT;
      slip_q  <= '0;
      gcnt_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fco_q   <= fco_d;
      fcnt_q  <= fcnt_d;
      frm_q   <= frm_d;
      state_q <= state_d;
      slip_q  <= slip_d;
      gcnt_q  <= gcnt_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  assign Data_VLD = vld_q;
  assign Data_CH  = dat_q;
  assign Locked   = (state_q == ST_LOCKED);
  assign Slip     = slip_q;
  assign Err_Cnt  = err_q;

endmodule

// File: tb/tb_adc_frame_deser.sv
`timescale 1ns/1ps
// Bench for adc_frame_deser: default build plus an 8-channel single-lane 12-bit build.
// Expected samples are queued with the DCO count at which they must appear;
// monitors pop and compare on every Data_VLD.

module tb_adc_frame_deser;

  localparam int A_CH = 4, A_RES = 14, A_LN = 2, A_LB = 8;
  localparam int B_CH = 8, B_RES = 12, B_LN = 1, B_LB = 12;

  logic DCO = 1'b0;
  always #5 DCO = ~DCO;

  logic                    rst_a_n, fr_a, ff_a, realign_a, vld_a, locked_a;
  logic [A_CH*A_LN-1:0]    dr_a, df_a;
  logic [A_CH*A_RES-1:0]   ch_a;
  logic [2:0]              slip_a;
  logic [15:0]             err_a;

  logic                    rst_b_n, fr_b, ff_b, realign_b, vld_b, locked_b;
  logic [B_CH*B_LN-1:0]    dr_b, df_b;
  logic [B_CH*B_RES-1:0]   ch_b;
  logic [3:0]              slip_b;
  logic [15:0]             err_b;

  adc_frame_deser u_a (
    .DCO(DCO), .RST_N(rst_a_n), .Data_R(dr_a), .Data_F(df_a), .FCO_R(fr_a), .FCO_F(ff_a),
    .Realign(realign_a), .Data_VLD(vld_a), .Data_CH(ch_a), .Locked(locked_a),
    .Slip(slip_a), .Err_Cnt(err_a)
  );

  adc_frame_deser #(.CHANNELS(B_CH), .RES(B_RES), .LANES(B_LN), .LANE_BITS(B_LB)) u_b (
    .DCO(DCO), .RST_N(rst_b_n), .Data_R(dr_b), .Data_F(df_b), .FCO_R(fr_b), .FCO_F(ff_b),
    .Realign(realign_b), .Data_VLD(vld_b), .Data_CH(ch_b), .Locked(locked_b),
    .Slip(slip_b), .Err_Cnt(err_b)
  );

  int errors = 0;
  int checks = 0;
  int ncyc_a, ncyc_b;
  int adv_a;
  logic [63:0] bad_a;

  typedef struct {
    int          cyc;
    logic [127:0] dat;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  // DCO rising edges since reset release.
  always @(posedge DCO or negedge rst_a_n) if (!rst_a_n) ncyc_a <= 0; else ncyc_a <= ncyc_a + 1;
  always @(posedge DCO or negedge rst_b_n) if (!rst_b_n) ncyc_b <= 0; else ncyc_b <= ncyc_b + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ex);
    end
  endtask

  // Channel 0 always carries 14'h2A5C; other channels change every frame.
  function automatic logic [15:0] samp(input int ch, input int f, input int res);
    logic [15:0] v;
    v = 16'h2A5C + 16'(ch) * (16'h0123 + 16'(f) * 16'h0041);
    return v & ((16'd1 << res) - 16'd1);
  endfunction

  // Bit q of the serial stream (MSB of each frame first). lane < 0 selects FCO.
  // Unused LSBs below the sample are padded with ones.
  function automatic logic gen_bit(input int lb, input int lanes, input int res, input int ch,
                                   input int lane, input int q, input logic [63:0] bad);
    int          f, j, w;
    logic [31:0] word;
    f = q / lb;
    j = q % lb;
    w = lanes * lb;
    if (lane < 0) return (j < lb / 2) ^ ((f < 64) && bad[f] && (j == 0));
    word = (32'(samp(ch, f, res)) << (w - res)) | ((32'd1 << (w - res)) - 32'd1);
    return word[lane*lb + lb - 1 - j];
  endfunction

  task automatic drive_a(input int k);
    for (int c = 0; c < A_CH; c++)
      for (int l = 0; l < A_LN; l++) begin
        df_a[c*A_LN+l] = gen_bit(A_LB, A_LN, A_RES, c, l, 2*k + adv_a, bad_a);
        dr_a[c*A_LN+l] = gen_bit(A_LB, A_LN, A_RES, c, l, 2*k + 1 + adv_a, bad_a);
      end
    ff_a = gen_bit(A_LB, A_LN, A_RES, 0, -1, 2*k + adv_a, bad_a);
    fr_a = gen_bit(A_LB, A_LN, A_RES, 0, -1, 2*k + 1 + adv_a, bad_a);
  endtask

  task automatic drive_b(input int k);
    for (int c = 0; c < B_CH; c++) begin
      df_b[c] = gen_bit(B_LB, B_LN, B_RES, c, 0, 2*k, 64'd0);
      dr_b[c] = gen_bit(B_LB, B_LN, B_RES, c, 0, 2*k + 1, 64'd0);
    end
    ff_b = gen_bit(B_LB, B_LN, B_RES, 0, -1, 2*k, 64'd0);
    fr_b = gen_bit(B_LB, B_LN, B_RES, 0, -1, 2*k + 1, 64'd0);
  endtask

  // Frame f is evaluated after the wrap edge ending it; its sample shows one edge later.
  task automatic push_a(input int f);
    exp_t        e;
    logic [15:0] s;
    e.dat = '0;
    for (int c = 0; c < A_CH; c++) begin
      s = samp(c, f, A_RES);
      e.dat[c*A_RES +: A_RES] = s[A_RES-1:0];
    end
    e.cyc = (f + 1) * (A_LB / 2) + 1;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int f);
    exp_t        e;
    logic [15:0] s;
    e.dat = '0;
    for (int c = 0; c < B_CH; c++) begin
      s = samp(c, f, B_RES);
      e.dat[c*B_RES +: B_RES] = s[B_RES-1:0];
    end
    e.cyc = (f + 1) * (B_LB / 2) + 1;
    q_b.push_back(e);
  endtask

  task automatic rst_chk_a(input string tag);
    chk({tag, "_vld"},    128'(vld_a),    128'd0);
    chk({tag, "_data"},   128'(ch_a),     128'd0);
    chk({tag, "_locked"}, 128'(locked_a), 128'd0);
    chk({tag, "_slip"},   128'(slip_a),   128'd0);
    chk({tag, "_err"},    128'(err_a),    128'd0);
  endtask

  always @(negedge DCO) begin
    if (rst_a_n && vld_a) begin : mon_a
      exp_t e;
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_vld: got data %0h at cycle %0d, expected no strobe", ch_a, ncyc_a);
      end else begin
        e = q_a.pop_front();
        chk("a_vld_cycle", 128'(ncyc_a), 128'(e.cyc));
        chk("a_data", 128'(ch_a), e.dat);
      end
    end
  end

  always @(negedge DCO) begin
    if (rst_b_n && vld_b) begin : mon_b
      exp_t e;
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_vld: got data %0h at cycle %0d, expected no strobe", ch_b, ncyc_b);
      end else begin
        e = q_b.pop_front();
        chk("b_vld_cycle", 128'(ncyc_b), 128'(e.cyc));
        chk("b_data", 128'(ch_b), e.dat);
      end
    end
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    dr_a = '0; df_a = '0; fr_a = 1'b0; ff_a = 1'b0; realign_a = 1'b0;
    dr_b = '0; df_b = '0; fr_b = 1'b0; ff_b = 1'b0; realign_b = 1'b0;
    adv_a = 0; bad_a = '0;
    repeat (3) @(negedge DCO);
    rst_chk_a("a_rst");
    chk("b_rst_vld",    128'(vld_b),    128'd0);
    chk("b_rst_data",   128'(ch_b),     128'd0);
    chk("b_rst_locked", 128'(locked_b), 128'd0);

    // Aligned stream: lock, loss after 4 bad frames, relock, Realign on a bad frame.
    bad_a[12] = 1'b1; bad_a[13] = 1'b1; bad_a[14] = 1'b1;
    bad_a[16] = 1'b1; bad_a[17] = 1'b1; bad_a[18] = 1'b1; bad_a[19] = 1'b1;
    bad_a[32] = 1'b1;
    for (int f = 8; f <= 11; f++) push_a(f);
    push_a(15);
    for (int f = 28; f <= 31; f++) push_a(f);
    for (int f = 41; f <= 44; f++) push_a(f);
    rst_a_n = 1'b1;
    for (int k = 0; k < 182; k++) begin
      case (k)
        29:  chk("a1_locked_f6", 128'(locked_a), 128'd0);
        33:  begin chk("a1_locked_f7", 128'(locked_a), 128'd1); chk("a1_err_f7", 128'(err_a), 128'd0); end
        61:  begin chk("a1_locked_f14", 128'(locked_a), 128'd1); chk("a1_err_f14", 128'(err_a), 128'd3); end
        77:  begin chk("a1_locked_f18", 128'(locked_a), 128'd1); chk("a1_err_f18", 128'(err_a), 128'd6); end
        81:  begin chk("a1_locked_f19", 128'(locked_a), 128'd0); chk("a1_err_f19", 128'(err_a), 128'd7); end
        133: begin
               chk("a1_realign_locked", 128'(locked_a), 128'd0);
               chk("a1_realign_err",    128'(err_a),    128'd7);
               chk("a1_realign_slip",   128'(slip_a),   128'd0);
             end
        161: chk("a1_relock_f39", 128'(locked_a), 128'd0);
        165: chk("a1_relock_f40", 128'(locked_a), 128'd1);
        default: ;
      endcase
      drive_a(k);
      realign_a = (k == 132);
      @(negedge DCO);
    end
    chk("a1_prerst_locked", 128'(locked_a), 128'd1);
    chk("a1_prerst_err",    128'(err_a),    128'd7);
    // Reset mid-frame while locked: outputs clear without waiting for a clock.
    #2 rst_a_n = 1'b0;
    #1 rst_chk_a("a_midrst");
    repeat (2) @(negedge DCO);

    // Word boundary three bits back in the window: hunt slips 0..3, then locks.
    adv_a = 3;
    bad_a = '0;
    for (int f = 14; f <= 19; f++) push_a(f);
    rst_a_n = 1'b1;
    for (int k = 0; k < 84; k++) begin
      case (k)
        4:  chk("a2_slip_f0_pre", 128'(slip_a), 128'd0);
        5:  chk("a2_slip_f0", 128'(slip_a), 128'd1);
        9:  chk("a2_slip_wait", 128'(slip_a), 128'd1);
        13: chk("a2_slip_f2", 128'(slip_a), 128'd2);
        21: chk("a2_slip_f4", 128'(slip_a), 128'd3);
        53: chk("a2_locked_f12", 128'(locked_a), 128'd0);
        57: chk("a2_locked_f13", 128'(locked_a), 128'd1);
        83: begin chk("a2_slip_end", 128'(slip_a), 128'd3); chk("a2_err_end", 128'(err_a), 128'd0); end
        default: ;
      endcase
      drive_a(k);
      @(negedge DCO);
    end
    rst_a_n = 1'b0;

    // 8 channels, one lane, 12-bit words: FCO 12'hFC0, strobe every 6 cycles.
    for (int f = 8; f <= 13; f++) push_b(f);
    rst_b_n = 1'b1;
    for (int k = 0; k < 88; k++) begin
      case (k)
        43: chk("b_locked_f6", 128'(locked_b), 128'd0);
        49: chk("b_locked_f7", 128'(locked_b), 128'd1);
        87: begin chk("b_slip_end", 128'(slip_b), 128'd0); chk("b_err_end", 128'(err_b), 128'd0); end
        default: ;
      endcase
      drive_b(k);
      @(negedge DCO);
    end

    chk("a_queue_empty", 128'(q_a.size()), 128'd0);
    chk("b_queue_empty", 128'(q_b.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
